oam_dma: RTL and testbench

Sprite-memory DMA engine sitting beside the 6502 core on the CPU bus. It snoops CPU writes to $4014. On a trigger it halts the core through `ready` and takes over the bus. It then copies the 256 bytes of CPU page `{page,8'h00}..{page,8'hFF}` to the PPU OAM data port at $2004 as read/write pairs, and returns the bus to the core.

---
 rtl/nes_pkg.sv | 15 +
 rtl/oam_dma.sv | 105 ++++++++++
 tb/tb_oam_dma.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
// Shared constants and state encoding for the NES CPU-side bus blocks.
package nes_pkg;

  localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite-memory DMA: snoops CPU writes to TRIG_ADDR, halts the core and copies
// one 256-byte CPU page to the PPU OAM data port as read/write pairs.
module oam_dma
  import nes_pkg::*;
#(
  parameter logic [15:0] TRIG_ADDR = OAM_DMA_ADDR,
  parameter logic [15:0] DEST_ADDR = OAMDATA_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_d_out,
  input  logic [7:0]  bus_d_in,
  output logic        ready,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_write,
  output logic [7:0]  dma_d_out
);

  dma_state_t state_q, state_d;
  logic       par_q;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       trig;

  assign trig = cpu_write && (cpu_addr == TRIG_ADDR);

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          page_d  = cpu_d_out;
          idx_d   = 8'h00;
          state_d = ST_HALT;
        end
      end
      // par_q=1 now means the next cycle is even, so READ can follow directly.
      ST_HALT:  state_d = par_q ? ST_READ : ST_ALIGN;
      ST_ALIGN: state_d = ST_READ;
      ST_READ: begin
        data_d  = bus_d_in;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == 8'hFF) ? ST_IDLE : ST_READ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready      = 1'b1;
    dma_active = 1'b0;
    dma_write  = 1'b0;
    dma_addr   = 16'h0000;
    case (state_q)
      ST_HALT, ST_ALIGN: begin
        ready      = 1'b0;
        dma_active = 1'b1;
        dma_addr   = cpu_addr;
      end
      ST_READ: begin
        ready      = 1'b0;
        dma_active = 1'b1;
        dma_addr   = {page_q, idx_q};
      end
      ST_WRITE: begin
        ready      = 1'b0;
        dma_active = 1'b1;
        dma_write  = 1'b1;
        dma_addr   = DEST_ADDR;
      end
      default: ;
    endcase
  end

  assign dma_d_out = data_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      par_q   <= 1'b0;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      par_q   <= ~par_q;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: builds the expected bus-cycle list of each
// transfer from the page contents and trigger parity, then compares cycle by cycle.
module tb_oam_dma;
  import nes_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_write;
  logic [7:0]  cpu_d_out;
  logic [7:0]  bus_d_in;
  logic        ready;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_write;
  logic [7:0]  dma_d_out;

  logic [7:0]  mem [0:65535];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  // Cycle number since the last reset; even cycles have an even number.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  assign bus_d_in = mem[dma_addr];

  oam_dma dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_write  (cpu_write),
    .cpu_d_out  (cpu_d_out),
    .bus_d_in   (bus_d_in),
    .ready      (ready),
    .dma_active (dma_active),
    .dma_addr   (dma_addr),
    .dma_write  (dma_write),
    .dma_d_out  (dma_d_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"},  32'(ready),      32'd1);
    check({tag, "_active"}, 32'(dma_active), 32'd0);
    check({tag, "_write"},  32'(dma_write),  32'd0);
  endtask

  // One full transfer. retrig_at / reset_at name the idx whose READ cycle
  // carries a CPU re-trigger write or a reset pulse (-1 for none).
  task automatic run_xfer(input logic [7:0] page, input bit late,
                          input int retrig_at, input int reset_at);
    logic [15:0] idle_addr;
    logic [15:0] e_addr[$];
    logic        e_wr[$];
    logic [7:0]  e_dat[$];
    int          n, stall, base, idx;

    idle_addr = 16'h8000 | 16'($urandom_range(0, 32767));
    base = late ? 2 : 1;
    for (int k = 0; k < base; k++) begin
      e_addr.push_back(idle_addr); e_wr.push_back(1'b0); e_dat.push_back(8'h00);
    end
    for (int i = 0; i < 256; i++) begin
      e_addr.push_back({page, 8'(i)});  e_wr.push_back(1'b0); e_dat.push_back(8'h00);
      e_addr.push_back(OAMDATA_ADDR);   e_wr.push_back(1'b1); e_dat.push_back(mem[{page, 8'(i)}]);
    end
    n = e_addr.size();

    @(negedge clk);
    cpu_addr  = idle_addr;
    cpu_write = 1'b0;
    if ((cyc % 2) != (late ? 1 : 0)) @(negedge clk);
    cpu_addr  = OAM_DMA_ADDR;
    cpu_write = 1'b1;
    cpu_d_out = page;
    @(posedge clk);
    #1;
    cpu_addr  = idle_addr;
    cpu_write = 1'b0;
    cpu_d_out = 8'($urandom);

    stall = 0;
    for (int s = 0; s <= n; s++) begin
      @(negedge clk);
      cpu_write = 1'b0;
      cpu_addr  = idle_addr;
      if (s < n) begin
        if (!ready) stall++;
        check("ready_low",  32'(ready),      32'd0);
        check("dma_active", 32'(dma_active), 32'd1);
        check("dma_addr",   32'(dma_addr),   32'(e_addr[s]));
        check("dma_write",  32'(dma_write),  32'(e_wr[s]));
        if (e_wr[s]) check("wdata", 32'(dma_d_out), 32'(e_dat[s]));
        if (dma_write) check("write_odd_cycle", 32'(cyc % 2), 32'd1);
        if (s >= base && ((s - base) % 2) == 0) begin
          idx = (s - base) / 2;
          if (idx == retrig_at) begin
            cpu_addr  = OAM_DMA_ADDR;
            cpu_write = 1'b1;
            cpu_d_out = 8'h07;
          end
          if (idx == reset_at) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check_idle("after_reset");
            check("after_reset_addr", 32'(dma_addr),  32'h0000);
            check("after_reset_data", 32'(dma_d_out), 32'h00);
            return;
          end
        end
      end else begin
        check_idle("release");
        check("stall_len", 32'(stall), late ? 32'd514 : 32'd513);
      end
    end
  endtask

  initial begin
    logic [15:0] other [3];
    reset     = 1'b1;
    cpu_addr  = 16'h0000;
    cpu_write = 1'b0;
    cpu_d_out = 8'h00;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle("reset");
    check("reset_addr", 32'(dma_addr),  32'h0000);
    check("reset_data", 32'(dma_d_out), 32'h00);

    run_xfer(8'h02, 1'b0, -1, -1);    // even alignment, 513-cycle stall
    run_xfer(8'h02, 1'b1, -1, -1);    // odd alignment, ALIGN inserted
    run_xfer(8'hFF, 1'b0, -1, -1);    // top page, no carry out of FFFF
    run_xfer(8'h02, 1'b0, 8'h40, -1); // re-trigger ignored
    run_xfer(8'h02, 1'b1, -1, 100);   // reset mid-transfer
    run_xfer(8'h02, 1'b0, -1, -1);    // restart from idx 0

    other[0] = 16'h4013;
    other[1] = 16'h4015;
    other[2] = 16'h2004;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cpu_addr  = other[k];
      cpu_write = 1'b1;
      cpu_d_out = 8'h03;
      @(negedge clk);
      cpu_write = 1'b0;
      cpu_addr  = 16'h8000;
      repeat (2) begin
        check_idle("no_trigger");
        @(negedge clk);
      end
    end

    for (int r = 0; r < 4; r++)
      run_xfer(8'($urandom), 1'($urandom), -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
